// File: rtl/dark_dma.sv
// rtl/dark_dma.sv - X-bus master that copies LEN words from SRC to DST, one read then one write per word.
// Optional wait timeout is compiled in with DARKDMA_TIMEOUT_EN.
module dark_dma #(
  parameter int LEN_W      = 16,
  parameter int TMO_CYCLES = 255
) (
  input  logic             CLK,
  input  logic             RESN,
  input  logic             START,
  input  logic [31:0]      SRC,
  input  logic [31:0]      DST,
  input  logic [LEN_W-1:0] LEN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [LEN_W-1:0] REMAIN,
  output logic             XDREQ,
  output logic             XRD,
  output logic             XWR,
  output logic [3:0]       XBE,
  output logic [31:0]      XADDR,
  output logic [31:0]      XATAI,
  input  logic [31:0]      XATAO,
  input  logic             XDACK
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]  state;
  logic [29:0] src_ptr;
  logic [29:0] dst_ptr;

`ifdef DARKDMA_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  logic [TMO_W-1:0] wait_cnt;
`endif

  // XATAI doubles as the holding register for the word in flight.
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      state   <= S_IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      REMAIN  <= '0;
      XDREQ   <= 1'b0;
      XRD     <= 1'b0;
      XWR     <= 1'b0;
      XBE     <= 4'b0000;
      XADDR   <= '0;
      XATAI   <= '0;
`ifdef DARKDMA_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            ERR     <= 1'b0;
            REMAIN  <= LEN;
            src_ptr <= SRC[31:2];
            dst_ptr <= DST[31:2];
            if (LEN != '0) begin
              state <= S_RD;
              BUSY  <= 1'b1;
              XDREQ <= 1'b1;
              XRD   <= 1'b1;
              XBE   <= 4'b1111;
              XADDR <= {SRC[31:2], 2'b00};
`ifdef DARKDMA_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              state <= S_FIN;
              DONE  <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (XDACK) begin
            XATAI <= XATAO;
            XRD   <= 1'b0;
            XWR   <= 1'b1;
            XADDR <= {dst_ptr, 2'b00};
            state <= S_WR;
`ifdef DARKDMA_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (wait_cnt == TMO_LAST) begin
            state <= S_FIN;
            ERR   <= 1'b1;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            XDREQ <= 1'b0;
            XRD   <= 1'b0;
            XBE   <= 4'b0000;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        S_WR: begin
          if (XDACK) begin
            REMAIN  <= REMAIN - 1'b1;
            src_ptr <= src_ptr + 30'd1;
            dst_ptr <= dst_ptr + 30'd1;
            XWR     <= 1'b0;
            if (REMAIN == LEN_W'(1)) begin
              state <= S_FIN;
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
              XDREQ <= 1'b0;
              XBE   <= 4'b0000;
            end else begin
              state <= S_RD;
              XRD   <= 1'b1;
              XADDR <= {src_ptr + 30'd1, 2'b00};
            end
`ifdef DARKDMA_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (wait_cnt == TMO_LAST) begin
            state <= S_FIN;
            ERR   <= 1'b1;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            XDREQ <= 1'b0;
            XWR   <= 1'b0;
            XBE   <= 4'b0000;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dark_dma.sv
// tb/tb_dark_dma.sv - directed vector bench for dark_dma against a RAM responder with programmable ack delays.
// Build with DARKDMA_TIMEOUT_EN defined to also exercise the wait timeout.
module tb_dark_dma;

  logic        CLK = 1'b0;
  logic        RESN;
  logic        START;
  logic [31:0] SRC;
  logic [31:0] DST;
  logic [15:0] LEN;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [15:0] REMAIN;
  logic        XDREQ;
  logic        XRD;
  logic        XWR;
  logic [3:0]  XBE;
  logic [31:0] XADDR;
  logic [31:0] XATAI;
  logic [31:0] XATAO;
  logic        XDACK;

  dark_dma #(.LEN_W(16), .TMO_CYCLES(8)) dut (
    .CLK(CLK), .RESN(RESN), .START(START), .SRC(SRC), .DST(DST), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .REMAIN(REMAIN),
    .XDREQ(XDREQ), .XRD(XRD), .XWR(XWR), .XBE(XBE), .XADDR(XADDR),
    .XATAI(XATAI), .XATAO(XATAO), .XDACK(XDACK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          rdw;
    int          wrw;
    int          pulse;
    int          done_cyc;
    int          busy;
    int          acks;
    logic [15:0] rem;
    logic        err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Responder: ack once the request has waited rd_wait / wr_wait cycles.
  logic [31:0] mem [0:1023];
  int    rd_wait = 1;
  int    wr_wait = 0;
  int    wcnt = 0;
  int    done_cnt = 0;
  int    unstable = 0;
  xact_t xlog[$];
  logic        prev_wait = 1'b0;
  logic        prev_rd = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;

  assign XATAO = mem[XADDR[11:2]];
  assign XDACK = XDREQ && (wcnt == (XRD ? rd_wait : wr_wait));

  always @(posedge CLK) begin
    if (!XDREQ || XDACK) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (DONE) done_cnt <= done_cnt + 1;
    if (prev_wait && XDREQ &&
        (XADDR != prev_addr || XRD != prev_rd || (XWR && XATAI != prev_data) || XBE != 4'hF))
      unstable <= unstable + 1;
    prev_wait <= XDREQ && !XDACK;
    prev_addr <= XADDR;
    prev_rd   <= XRD;
    prev_data <= XATAI;
    if (XDACK) begin
      xlog.push_back('{wr: XWR, addr: XADDR, data: (XWR ? XATAI : XATAO)});
      if (XWR) mem[XADDR[11:2]] = XATAI;
    end
  end

  function automatic logic [31:0] pat(input int idx, input int seed);
    return 32'h9E370000 ^ 32'(idx * 32'h00010203) ^ 32'(seed << 20);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int seed);
    int cyc;
    int busy_cyc;
    int req_cyc;
    int errs;
    logic got_done;
    logic [31:0] a;
    logic [31:0] d;
    rd_wait = v.rdw;
    wr_wait = v.wrw;
    for (int j = 0; j < 1024; j++) mem[j] = pat(j, seed);
    @(negedge CLK);
    xlog.delete();
    SRC = v.src; DST = v.dst; LEN = v.len; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    cyc = 1; busy_cyc = 0; req_cyc = 0; got_done = 1'b0;
    chk($sformatf("v%0d remain_load", seed), 64'(REMAIN), 64'(v.len));
    while (cyc <= 400) begin
      if (cyc == v.pulse) begin SRC = 32'h700; LEN = 16'd9; START = 1'b1; end
      else START = 1'b0;
      if (BUSY) busy_cyc++;
      if (XDREQ) req_cyc++;
      if (DONE) begin got_done = 1'b1; break; end
      @(posedge CLK); #1;
      cyc++;
    end
    START = 1'b0;
    chk($sformatf("v%0d done_seen", seed), 64'(got_done), 64'd1);
    chk($sformatf("v%0d done_cycle", seed), 64'(cyc), 64'(v.done_cyc));
    chk($sformatf("v%0d busy_cycles", seed), 64'(busy_cyc), 64'(v.busy));
    chk($sformatf("v%0d xdreq_cycles", seed), 64'(req_cyc), 64'(v.busy));
    chk($sformatf("v%0d err", seed), 64'(ERR), 64'(v.err));
    chk($sformatf("v%0d remain_end", seed), 64'(REMAIN), 64'(v.rem));
    @(posedge CLK); #1;
    chk($sformatf("v%0d done_one_cycle", seed), {62'd0, DONE, BUSY}, 64'd0);
    chk($sformatf("v%0d acks", seed), 64'(xlog.size()), 64'(v.acks));
    errs = 0;
    if (xlog.size() != v.acks) errs++;
    else begin
      for (int i = 0; i < v.acks / 2; i++) begin
        a = {v.src[31:2], 2'b00} + 32'(i * 4);
        d = {v.dst[31:2], 2'b00} + 32'(i * 4);
        if (xlog[2*i].wr !== 1'b0 || xlog[2*i].addr !== a) errs++;
        if (xlog[2*i+1].wr !== 1'b1 || xlog[2*i+1].addr !== d ||
            xlog[2*i+1].data !== pat(int'(a[11:2]), seed)) errs++;
        if (mem[d[11:2]] !== pat(int'(a[11:2]), seed)) errs++;
      end
    end
    chk($sformatf("v%0d xact_order_data", seed), 64'(errs), 64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int n;
    int d0;
    vecs[0] = '{src: 32'h100, dst: 32'h200, len: 16'd4, rdw: 1, wrw: 0, pulse: 0,
                done_cyc: 13, busy: 12, acks: 8, rem: 16'd0, err: 1'b0};
    vecs[1] = '{src: 32'h100, dst: 32'h200, len: 16'd0, rdw: 1, wrw: 0, pulse: 0,
                done_cyc: 1, busy: 0, acks: 0, rem: 16'd0, err: 1'b0};
    vecs[2] = '{src: 32'h042, dst: 32'h301, len: 16'd3, rdw: 3, wrw: 2, pulse: 0,
                done_cyc: 22, busy: 21, acks: 6, rem: 16'd0, err: 1'b0};
    vecs[3] = '{src: 32'h010, dst: 32'h020, len: 16'd1, rdw: 0, wrw: 0, pulse: 0,
                done_cyc: 3, busy: 2, acks: 2, rem: 16'd0, err: 1'b0};
    vecs[4] = '{src: 32'hFFFFFFFC, dst: 32'h500, len: 16'd2, rdw: 1, wrw: 0, pulse: 3,
                done_cyc: 7, busy: 6, acks: 4, rem: 16'd0, err: 1'b0};

    RESN = 1'b0; START = 1'b0; SRC = '0; DST = '0; LEN = '0;
    for (int j = 0; j < 1024; j++) mem[j] = '0;
    #1;
    chk("reset_outputs", {BUSY, DONE, ERR, XDREQ, XRD, XWR, XBE, REMAIN, XADDR, XATAI},
        '0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); RESN = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Reset asserted while a write waits for its ack.
    rd_wait = 1; wr_wait = 5;
    @(negedge CLK);
    SRC = 32'h100; DST = 32'h600; LEN = 16'd3; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    n = 0;
    while (!XWR && n < 50) begin @(posedge CLK); #1; n++; end
    chk("rst_reach_wr", 64'(XWR), 64'd1);
    repeat (2) @(posedge CLK);
    d0 = done_cnt;
    @(negedge CLK); #2;
    RESN = 1'b0;
    #1;
    chk("rst_async_drop", {61'd0, XDREQ, XWR, BUSY}, 64'd0);
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
    @(negedge CLK); RESN = 1'b1;
    run_vec(vecs[0], 7);

`ifdef DARKDMA_TIMEOUT_EN
    run_vec('{src: 32'h100, dst: 32'h200, len: 16'd5, rdw: 1000, wrw: 0, pulse: 0,
              done_cyc: 9, busy: 8, acks: 0, rem: 16'd5, err: 1'b1}, 8);
    run_vec(vecs[3], 9);
`endif

    chk("handshake_stable", 64'(unstable), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dark_dma.md
Name: dark_dma

Overview:
- Bus-master copy engine: the initiator end of the X-bus (XDREQ/XRD/XWR/XBE/XADDR/XATAI/XATAO/XDACK) that the on-chip dual-port RAM responds to.
- Copies LEN 32-bit words from SRC to DST by alternating one read and one write transaction per word.
- Sits beside the core on the shared data bus; driven by simple control strobes from a register block.

Parameters:
- LEN_W, 16, width of the word-count input and the REMAIN output.
- TMO_CYCLES, 255, wait cycles without XDACK before a transaction is aborted (only used with DARKDMA_TIMEOUT_EN).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESN  in  1  reset: one clock; asynchronous, active-low.
- START  in  1  one-cycle pulse, sampled in IDLE only.
- SRC  in  32  source byte address; bits [1:0] ignored.
- DST  in  32  destination byte address; bits [1:0] ignored.
- LEN  in  LEN_W  word count.
- BUSY  out  1  high from the cycle after START until DONE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  sticky timeout flag; cleared by next accepted START.
- REMAIN  out  LEN_W  words not yet written.
- XDREQ  out  1  bus request.
- XRD  out  1  read strobe.
- XWR  out  1  write strobe.
- XBE  out  4  byte enables; always 4'b1111 while XDREQ is high, 0 otherwise.
- XADDR  out  32  word-aligned address; [1:0]=0.
- XATAI  out  32  write data, driven to the responder's XATAI.
- XATAO  in  32  read data from the responder; valid while XDACK is high.
- XDACK  in  1  responder acknowledge.

Behaviour:
- All outputs come from registers (Moore).
- Async reset state: all outputs 0, FSM in IDLE, ERR=0.
- FSM states: IDLE, RD, WR, FIN.
- IDLE:
  - START && LEN!=0: latch SRC/DST (word-aligned), load REMAIN=LEN, go RD, BUSY=1.
  - START && LEN==0: go FIN with no bus activity.
  - START is ignored in every state other than IDLE.
- RD:
  - Drive XDREQ=1, XRD=1, XADDR=src pointer.
  - On the edge where XDACK=1: capture XATAO into a holding register, go WR.
- WR:
  - Drive XDREQ=1, XWR=1, XADDR=dst pointer, XATAI=holding register.
  - On the edge where XDACK=1: REMAIN-=1, both pointers +=4 (32-bit wrap, 0xFFFFFFFC -> 0).
  - If REMAIN was 1, go FIN; else go RD.
- FIN: DONE=1 and BUSY=0 for one cycle, all X-bus strobes 0, then go IDLE.
- Handshake rules:
  - XDREQ, XRD/XWR, XADDR and XATAI are held stable until XDACK is sampled high.
  - XDACK may arrive in the same cycle as the request (combinational write ack) or N cycles later.
  - XDACK sampled while XDREQ=0 is ignored.
  - Back-to-back transactions are allowed without an idle cycle; strobe type changes at the ack edge.
- Latency against a 1-cycle-read / 0-cycle-write responder:
  - 3 cycles per word.
  - The first XDREQ is high in the cycle after the START sample edge.
  - DONE is high 3*LEN+1 cycles after the START sample edge.
- RESN asserted mid-transfer: the X-bus drops immediately; the transfer is lost and no DONE is issued.

Optional Feature:
- Macro DARKDMA_TIMEOUT_EN.
- With the macro:
  - A wait counter clears on entry to RD/WR and increments each cycle without XDACK.
  - When it reaches TMO_CYCLES: drop XDREQ next cycle, set ERR=1, go FIN (DONE pulses).
  - REMAIN keeps its value for software.
- Without the macro: no counter; the FSM waits indefinitely; ERR is tied 0.

Test Plan:
- LEN=4, SRC=0x100, DST=0x200, RAM responder -> 4 reads then 4 writes interleaved; DST words equal SRC words; DONE once at START+13; REMAIN 4->0.
- LEN=0 -> DONE at START+1, XDREQ never asserted, BUSY stays 0.
- Responder with 3-cycle read ack and 2-cycle write ack -> XADDR/XATAI stable throughout each wait; exactly 2*LEN acks consumed; no duplicate transactions.
- DARKDMA_TIMEOUT_EN, TMO_CYCLES=8, responder never acks -> XDREQ drops after 8 wait cycles, ERR=1, DONE pulse, REMAIN=LEN; next START clears ERR.
- RESN low during a WR wait with LEN=3 -> XDREQ/XWR/BUSY low without a clock edge; no DONE; after release a fresh START completes normally.
- START pulsed while BUSY, plus SRC=0xFFFFFFFC with LEN=2 -> second START ignored; read addresses 0xFFFFFFFC then 0x00000000.
